// File: rtl/mdu_issue_ctrl.sv
// mdu_issue_ctrl: E-stage issue controller for the multiply/divide unit.
//
// Decodes the E-stage MD operation, drives start/ctrl/operands to the MDU and
// tracks the MDU's fixed latency with a shadow FSM. Any MD instruction that
// would collide with an in-flight operation stalls E, and a flush from M
// suppresses issue.
//
// Ports:
//   clk, reset         clock; synchronous active-high reset
//   e_valid_i          E stage holds a valid instruction
//   e_md_op_i          MD opcode (0 none, 1 mult, 2 multu, 3 div, 4 divu,
//                      5 mfhi, 6 mflo, 7 mthi, 8 mtlo)
//   e_src_a_i/_b_i     forwarded rs/rt values
//   flush_req_i        M-stage exception/interrupt cancels the E instruction
//   mdu_busy_i         busy reported by the MDU
//   mdu_start_o        one-cycle start pulse to the MDU
//   mdu_ctrl_o         opcode to the MDU (0 unless issued)
//   mdu_src_a_o/_b_o   operands to the MDU (unregistered pass-through)
//   stall_e_o          freeze F/D/E, bubble into M
//   hilo_sel_o         E result mux: 1 = HI, 0 = LO
//   track_busy_o       shadow FSM busy
//   perf_bus_o         (MDU_PERF_EN only) {flush-suppressed starts, stall cycles,
//                      issued arith ops}, each 32-bit saturating
//
// Optional feature macro: MDU_PERF_EN.

module mdu_issue_ctrl #(
  parameter int unsigned MUL_LAT = 5,
  parameter int unsigned DIV_LAT = 50,
  parameter int unsigned CNT_W   = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        e_valid_i,
  input  logic [3:0]  e_md_op_i,
  input  logic [31:0] e_src_a_i,
  input  logic [31:0] e_src_b_i,
  input  logic        flush_req_i,
  input  logic        mdu_busy_i,
  output logic        mdu_start_o,
  output logic [3:0]  mdu_ctrl_o,
  output logic [31:0] mdu_src_a_o,
  output logic [31:0] mdu_src_b_o,
  output logic        stall_e_o,
  output logic        hilo_sel_o,
  output logic        track_busy_o
`ifdef MDU_PERF_EN
  ,
  output logic [95:0] perf_bus_o
`endif
);

  typedef enum logic [1:0] {StIdle, StWaitMul, StWaitDiv} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic md, arith, is_mul, issue;

  // Decode and issue logic
  always_comb begin
    md     = e_valid_i && (e_md_op_i >= 4'd1) && (e_md_op_i <= 4'd8);
    arith  = e_valid_i && (e_md_op_i >= 4'd1) && (e_md_op_i <= 4'd4);
    is_mul = (e_md_op_i == 4'd1) || (e_md_op_i == 4'd2);

    track_busy_o = (state_q != StIdle);
    // Either busy source alone must stall: the MDU may be busy from an
    // operation this block never saw, and the shadow covers the MDU's
    // start-to-busy gap.
    stall_e_o    = md && (track_busy_o || mdu_busy_i);
    issue        = md && !stall_e_o && !flush_req_i;
    mdu_start_o  = issue && arith;
    mdu_ctrl_o   = issue ? e_md_op_i : 4'd0;
    mdu_src_a_o  = e_src_a_i;
    mdu_src_b_o  = e_src_b_i;
    hilo_sel_o   = (e_md_op_i == 4'd5);
  end

  // Shadow latency FSM: busy for exactly MUL_LAT/DIV_LAT cycles after start
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (mdu_start_o) begin
          state_d = is_mul ? StWaitMul : StWaitDiv;
          cnt_d   = CNT_W'(1);
        end
      end
      StWaitMul: begin
        if (cnt_q == CNT_W'(MUL_LAT)) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      StWaitDiv: begin
        if (cnt_q == CNT_W'(DIV_LAT)) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef MDU_PERF_EN
  logic [31:0] perf_issue_q, perf_stall_q, perf_supp_q;
  logic        supp;

  // A start that would have fired but for the flush
  assign supp = arith && !stall_e_o && flush_req_i;

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_issue_q <= '0;
      perf_stall_q <= '0;
      perf_supp_q  <= '0;
    end else begin
      if (mdu_start_o && !(&perf_issue_q)) perf_issue_q <= perf_issue_q + 32'd1;
      if (stall_e_o && !(&perf_stall_q))   perf_stall_q <= perf_stall_q + 32'd1;
      if (supp && !(&perf_supp_q))         perf_supp_q  <= perf_supp_q + 32'd1;
    end
  end

  assign perf_bus_o = {perf_supp_q, perf_stall_q, perf_issue_q};
`endif

endmodule

// File: tb/tb_mdu_issue_ctrl.sv
// Self-checking bench for mdu_issue_ctrl: directed scenarios followed by
// randomized traffic, all compared against a behavioural model that keeps a
// simple "busy cycles left" count for the MDU operation in flight.

module tb_mdu_issue_ctrl;

  localparam int unsigned MulLat = 5;
  localparam int unsigned DivLat = 50;

  logic        clk = 1'b0;
  logic        reset;
  logic        e_valid;
  logic [3:0]  e_md_op;
  logic [31:0] e_src_a, e_src_b;
  logic        flush_req;
  logic        mdu_busy;
  logic        mdu_start;
  logic [3:0]  mdu_ctrl;
  logic [31:0] mdu_src_a, mdu_src_b;
  logic        stall_e;
  logic        hilo_sel;
  logic        track_busy;
`ifdef MDU_PERF_EN
  logic [95:0] perf_bus;
  logic [31:0] p_iss, p_stl, p_sup;
`endif

  int errors = 0;
  int checks = 0;
  int busy_left = 0;  // model: cycles the MDU op in flight still occupies
  logic obs_stall, obs_start, obs_hilo;
  logic [3:0] obs_ctrl;

  always #5 clk = ~clk;

  mdu_issue_ctrl #(
    .MUL_LAT(MulLat),
    .DIV_LAT(DivLat),
    .CNT_W  (6)
  ) u_dut (
    .clk         (clk),
    .reset       (reset),
    .e_valid_i   (e_valid),
    .e_md_op_i   (e_md_op),
    .e_src_a_i   (e_src_a),
    .e_src_b_i   (e_src_b),
    .flush_req_i (flush_req),
    .mdu_busy_i  (mdu_busy),
    .mdu_start_o (mdu_start),
    .mdu_ctrl_o  (mdu_ctrl),
    .mdu_src_a_o (mdu_src_a),
    .mdu_src_b_o (mdu_src_b),
    .stall_e_o   (stall_e),
    .hilo_sel_o  (hilo_sel),
    .track_busy_o(track_busy)
`ifdef MDU_PERF_EN
    ,
    .perf_bus_o  (perf_bus)
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, compare against the model, advance the model.
  task automatic step(input logic rst, input logic v, input logic [3:0] op,
                      input logic [31:0] a, input logic [31:0] b,
                      input logic fl, input logic xbusy);
    logic md, arith, busy, stall, start;
    logic [3:0] ctrl;
    @(negedge clk);
    reset     = rst;
    e_valid   = v;
    e_md_op   = op;
    e_src_a   = a;
    e_src_b   = b;
    flush_req = fl;
    mdu_busy  = (busy_left > 0) || xbusy;

    md    = v && (op >= 4'd1) && (op <= 4'd8);
    arith = v && (op >= 4'd1) && (op <= 4'd4);
    busy  = busy_left > 0;
    stall = md && (busy || mdu_busy);
    start = arith && !stall && !fl;
    ctrl  = (md && !stall && !fl) ? op : 4'd0;

    #1;
    obs_stall = stall_e;
    obs_start = mdu_start;
    obs_ctrl  = mdu_ctrl;
    obs_hilo  = hilo_sel;
    check_eq("track_busy", 32'(track_busy), 32'(busy));
    check_eq("stall_e", 32'(stall_e), 32'(stall));
    check_eq("mdu_start", 32'(mdu_start), 32'(start));
    check_eq("mdu_ctrl", 32'(mdu_ctrl), 32'(ctrl));
    check_eq("hilo_sel", 32'(hilo_sel), 32'(op == 4'd5));
    check_eq("mdu_src_a", mdu_src_a, a);
    check_eq("mdu_src_b", mdu_src_b, b);
`ifdef MDU_PERF_EN
    check_eq("perf_issue", perf_bus[31:0], p_iss);
    check_eq("perf_stall", perf_bus[63:32], p_stl);
    check_eq("perf_supp", perf_bus[95:64], p_sup);
`endif

    @(posedge clk);
    if (rst) begin
      busy_left = 0;
    end else if (busy_left > 0) begin
      busy_left--;
    end else if (start) begin
      busy_left = ((op == 4'd1) || (op == 4'd2)) ? int'(MulLat) : int'(DivLat);
    end
`ifdef MDU_PERF_EN
    if (rst) begin
      p_iss = 0; p_stl = 0; p_sup = 0;
    end else begin
      if (start && p_iss != 32'hFFFF_FFFF) p_iss++;
      if (stall && p_stl != 32'hFFFF_FFFF) p_stl++;
      if (arith && !stall && fl && p_sup != 32'hFFFF_FFFF) p_sup++;
    end
`endif
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 1'b0);
  endtask

  initial begin
    reset = 1'b1; e_valid = 1'b0; e_md_op = 4'd0; e_src_a = '0; e_src_b = '0;
    flush_req = 1'b0; mdu_busy = 1'b0;
`ifdef MDU_PERF_EN
    p_iss = 0; p_stl = 0; p_sup = 0;
`endif
    repeat (2) @(posedge clk);
    step(1'b1, 1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    check_eq("reset_track", 32'(track_busy), 32'd0);

    // mult 3*5 then mflo: stalled 5 cycles, issues on the 6th
    step(1'b0, 1'b1, 4'd1, 32'd3, 32'd5, 1'b0, 1'b0);
    check_eq("t1_start", 32'(obs_start), 32'd1);
    for (int i = 1; i <= 5; i++) begin
      step(1'b0, 1'b1, 4'd6, 32'd0, 32'd0, 1'b0, 1'b0);
      check_eq("t1_stall", 32'(obs_stall), 32'd1);
      check_eq("t1_nostart", 32'(obs_start), 32'd0);
    end
    step(1'b0, 1'b1, 4'd6, 32'd0, 32'd0, 1'b0, 1'b0);
    check_eq("t1_mflo_ctrl", 32'(obs_ctrl), 32'd6);
    check_eq("t1_mflo_hilo", 32'(obs_hilo), 32'd0);

    // div, then mthi from cycle 10: held through cycle 50, issues at 51
    step(1'b0, 1'b1, 4'd3, 32'd100, 32'd7, 1'b0, 1'b0);
    idle_cycles(9);
    for (int c = 10; c <= 50; c++) begin
      step(1'b0, 1'b1, 4'd7, 32'd9, 32'd0, 1'b0, 1'b0);
      check_eq("t2_stall", 32'(obs_stall), 32'd1);
    end
    step(1'b0, 1'b1, 4'd7, 32'd9, 32'd0, 1'b0, 1'b0);
    check_eq("t2_mthi_ctrl", 32'(obs_ctrl), 32'd7);

    // flushed mult never starts; following div issues at once
    step(1'b0, 1'b1, 4'd1, 32'd2, 32'd2, 1'b1, 1'b0);
    check_eq("t3_flush_start", 32'(obs_start), 32'd0);
    step(1'b0, 1'b1, 4'd3, 32'd8, 32'd2, 1'b0, 1'b0);
    check_eq("t3_div_start", 32'(obs_start), 32'd1);
    check_eq("t3_div_ctrl", 32'(obs_ctrl), 32'd3);

    // reset 20 cycles into that div, then a mult issues without stall
    idle_cycles(19);
    step(1'b1, 1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 4'd1, 32'd4, 32'd4, 1'b0, 1'b0);
    check_eq("t5_mult_start", 32'(obs_start), 32'd1);

    // back-to-back multu: second waits 5 cycles
    idle_cycles(MulLat);
    step(1'b0, 1'b1, 4'd2, 32'd1, 32'd1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 4'd2, 32'd1, 32'd1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 4'd2, 32'd1, 32'd1, 1'b0, 1'b0);
    check_eq("t4_second_start", 32'(obs_start), 32'd1);
    idle_cycles(MulLat);

    // external MDU busy alone stalls mfhi
    step(1'b0, 1'b1, 4'd5, 32'd0, 32'd0, 1'b0, 1'b1);
    check_eq("t6_stall", 32'(obs_stall), 32'd1);
    check_eq("t6_ctrl", 32'(obs_ctrl), 32'd0);
    check_eq("t6_hilo", 32'(obs_hilo), 32'd1);

    // randomized traffic
    for (int n = 0; n < 4000; n++) begin
      step($urandom_range(0, 199) == 0, $urandom_range(0, 9) < 8,
           4'($urandom_range(0, 10)), $urandom, $urandom,
           $urandom_range(0, 9) == 0, $urandom_range(0, 19) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
